// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one W-bit output mux between N_REQ requesters.
// Each owner keeps the mux for at most MAX_HOLD beats, then priority rotates past it.
module rr_mux_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       data,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic [W-1:0]             mux_out,
  output logic                     out_valid,
  output logic                     busy
);
  localparam int SW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [SW-1:0] LAST_IDX  = SW'(N_REQ - 1);
  localparam logic [HW-1:0] LAST_BEAT = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [SW-1:0] owner, owner_n, ptr, ptr_n, next_idx;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          release_now;

  // First requester found scanning upward from p, wrapping modulo N_REQ.
  function automatic logic [SW-1:0] winner(input logic [N_REQ-1:0] r,
                                           input logic [SW-1:0]    p);
    logic found;
    int   idx;
    winner = p;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        winner = SW'(idx);
        found  = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign next_idx    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign release_now = !req[owner] || (hold_cnt == LAST_BEAT);

  // A release hands straight to the next winner so there is no idle bubble.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = winner(req, ptr);
          hold_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n  = next_idx;
          hold_n = '0;
          if (|req) begin
            owner_n = winner(req, next_idx);
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    sel       = '0;
    mux_out   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state == GRANT) begin
      gnt[owner] = 1'b1;
      sel        = owner;
      mux_out    = data[int'(owner)*W +: W];
      out_valid  = req[owner];
      busy       = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic,
// compared against a queue-free behavioural model of round-robin ownership.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int VW = N + SW + W + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0, req1 = '0;
  logic [N*W-1:0] data = '0, data1 = '0;
  logic [N-1:0]   gnt, gnt1;
  logic [SW-1:0]  sel, sel1;
  logic [W-1:0]   mux_out, mux_out1;
  logic           out_valid, out_valid1, busy, busy1;

  int errors = 0;
  int checks = 0;

  // Model: owner -1 means idle; beats counts granted cycles in the current ownership.
  int m_owner[2] = '{-1, -1};
  int m_ptr[2]   = '{0, 0};
  int m_beats[2] = '{0, 0};
  int m_hold[2]  = '{8, 1};

  rr_mux_arbiter #(.N_REQ(N), .W(W), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt), .sel(sel),
    .mux_out(mux_out), .out_valid(out_valid), .busy(busy));

  rr_mux_arbiter #(.N_REQ(N), .W(W), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .data(data1), .gnt(gnt1), .sel(sel1),
    .mux_out(mux_out1), .out_valid(out_valid1), .busy(busy1));

  always #5 clk = ~clk;

  function automatic void model_step(int u, logic [N-1:0] r);
    int start;
    if (m_owner[u] >= 0) begin
      m_beats[u] = m_beats[u] + 1;
      if (r[m_owner[u]] && m_beats[u] < m_hold[u]) return;
      m_ptr[u] = (m_owner[u] + 1) % N;
    end
    start      = m_ptr[u];
    m_owner[u] = -1;
    m_beats[u] = 0;
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) begin
        m_owner[u] = (start + k) % N;
        break;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_owner[u] = -1;
        m_ptr[u]   = 0;
        m_beats[u] = 0;
      end
    end else begin
      model_step(0, req);
      model_step(1, req1);
    end
  end

  // Expected {gnt, sel, mux_out, out_valid, busy} from the model's view of ownership.
  function automatic logic [VW-1:0] expv(int u, logic [N-1:0] r, logic [N*W-1:0] d);
    logic [N-1:0] g;
    int o;
    o = m_owner[u];
    if (o < 0) return '0;
    g    = '0;
    g[o] = 1'b1;
    return {g, SW'(o), d[o*W +: W], r[o], 1'b1};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({gnt, sel, mux_out, out_valid, busy, gnt1, busy1} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_hold got=%h/%h required=0", {gnt, sel, mux_out, out_valid, busy}, {gnt1, busy1});
      end
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({gnt, sel, mux_out, out_valid, busy} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle got=%h required=0", {gnt, sel, mux_out, out_valid, busy});
      end
    end
  endtask

  task automatic test_single();
    data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({gnt, sel, mux_out, out_valid, busy} !== {4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_first got=%h required=%h", {gnt, sel, mux_out, out_valid, busy}, {4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1});
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || {gnt, sel, mux_out, out_valid, busy} !== expv(0, req, data)) begin
        errors++;
        $display("[TB] FAIL single_hold got=%h required=%h", {gnt, sel, mux_out, out_valid, busy}, expv(0, req, data));
      end
    end
    req = '0;
  endtask

  task automatic test_contention();
    logic [N-1:0] g_exp;
    int o;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) data[i*W +: W] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      o = (c / 8) % N;
      g_exp = 4'b0001 << o;
      checks++;
      if (gnt !== g_exp || mux_out !== 8'h10 + 8'(o) || {gnt, sel, mux_out, out_valid, busy} !== expv(0, req, data)) begin
        errors++;
        $display("[TB] FAIL contention c=%0d gnt=%b mux=%h required gnt=%b mux=%h", c, gnt, mux_out, g_exp, 8'h10 + 8'(o));
      end
    end
    req = '0;
  endtask

  task automatic test_early_release();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL early_owner1 gnt=%b required=0010", gnt);
      end
    end
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("[TB] FAIL early_handover gnt=%b sel=%0d required gnt=1000 sel=3", gnt, sel);
    end
    req = 4'b0111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || {gnt, sel, mux_out, out_valid, busy} !== expv(0, req, data)) begin
      errors++;
      $display("[TB] FAIL early_wrap gnt=%b required=0001", gnt);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    repeat (6) @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL midburst_owner gnt=%b required=0100", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, sel, mux_out, out_valid, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL midburst_async got=%h required=0", {gnt, sel, mux_out, out_valid, busy});
    end
    req = 4'b1111;
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midburst_restart gnt=%b sel=%0d required gnt=0001 sel=0", gnt, sel);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_max_hold1();
    logic [N-1:0] g_exp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data1 = $urandom;
    req1 = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      g_exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (gnt1 !== g_exp || out_valid1 !== 1'b1 || {gnt1, sel1, mux_out1, out_valid1, busy1} !== expv(1, req1, data1)) begin
        errors++;
        $display("[TB] FAIL hold1 c=%0d gnt=%b valid=%b required gnt=%b valid=1", c, gnt1, out_valid1, g_exp);
      end
    end
    req1 = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req  = N'($urandom);
      if ($urandom_range(0, 3) == 0) req1 = N'($urandom);
      data  = $urandom;
      data1 = $urandom;
      if ($urandom_range(0, 150) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({gnt, sel, mux_out, out_valid, busy} !== expv(0, req, data)) begin
        errors++;
        $display("[TB] FAIL random_h8 c=%0d got=%h required=%h", c, {gnt, sel, mux_out, out_valid, busy}, expv(0, req, data));
      end
      checks++;
      if ({gnt1, sel1, mux_out1, out_valid1, busy1} !== expv(1, req1, data1)) begin
        errors++;
        $display("[TB] FAIL random_h1 c=%0d got=%h required=%h", c, {gnt1, sel1, mux_out1, out_valid1, busy1}, expv(1, req1, data1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_reset_midburst();
    test_max_hold1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
